// File: rtl/tone_preset_gen_if.sv
// tone_preset_gen_if
//   Bundles the note-source inputs and preset/display outputs of
//   tone_preset_gen. Names carry the DUT's view: _i driven into the
//   generator, _o driven by it.
//   master : note sources (sequencer, keypad, control) side
//   slave  : tone_preset_gen side
//   Signals:
//     mode_i       note source select, 0 = ROM, 1 = keypad
//     rom_note_i   {octave, degree[2:0]} from the song ROM
//     rom_stb_i    rom_note_i is sampled while high
//     key_note_i   keypad note word, same format
//     key_down_i   debounced key-held level
//     oct_shift_i  signed octave shift, -2..+1
//     clr_bad_i    clears bad_note_o
//     to_o         divider preset
//     code_o       note degree 1..7, 0 = rest
//     oct_o        effective octave
//     mute_o       1 = rest
//     to_load_o    one-cycle pulse when {to_o, mute_o} changes
//     bad_note_o   sticky invalid-octave flag
interface tone_preset_gen_if #(
    parameter int TO_W  = 12,
    parameter int OCT_W = 2
);
    logic                    mode_i;
    logic [OCT_W+2:0]        rom_note_i;
    logic                    rom_stb_i;
    logic [OCT_W+2:0]        key_note_i;
    logic                    key_down_i;
    logic signed [1:0]       oct_shift_i;
    logic                    clr_bad_i;
    logic [TO_W-1:0]         to_o;
    logic [2:0]              code_o;
    logic [OCT_W-1:0]        oct_o;
    logic                    mute_o;
    logic                    to_load_o;
    logic                    bad_note_o;

    modport master (
        output mode_i, rom_note_i, rom_stb_i, key_note_i, key_down_i,
               oct_shift_i, clr_bad_i,
        input  to_o, code_o, oct_o, mute_o, to_load_o, bad_note_o
    );

    modport slave (
        input  mode_i, rom_note_i, rom_stb_i, key_note_i, key_down_i,
               oct_shift_i, clr_bad_i,
        output to_o, code_o, oct_o, mute_o, to_load_o, bad_note_o
    );
endinterface

// File: rtl/tone_preset_gen.sv
// tone_preset_gen
//   Turns a note word (from the song ROM or the keypad) into the divider
//   preset for the speaker's preset-load counter. Tone period is
//   2^TO_W - TO. Notes move through capture -> decode -> period -> output
//   registers, so a note sampled at edge n is visible after edge n+3.
//   Ports:
//     clk_i   system clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     tone_preset_gen_if.slave (note inputs, preset/display outputs)
module tone_preset_gen #(
    parameter int TO_W    = 12,
    parameter int OCT_W   = 2,
    parameter int OCTAVES = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tone_preset_gen_if.slave  bus
);

    localparam int NW = OCT_W + 3;
    localparam logic [OCT_W-1:0]        TOP_OCT   = OCT_W'(OCTAVES - 1);
    localparam logic signed [OCT_W+1:0] TOP_OCT_S = (OCT_W + 2)'(OCTAVES - 1);
    localparam logic [OCT_W:0]          OCT_LIMIT = (OCT_W + 1)'(OCTAVES);

    // The longest period (degree 1, lowest octave) must fit below 2^TO_W
    // so that 2^TO_W - period never wraps.
    if ((longint'(638) << (OCTAVES - 1)) >= (longint'(1) << TO_W)) begin : g_to_w_check
        $error("tone_preset_gen: TO_W too small for OCTAVES");
    end
    if ((OCTAVES < 1) || (OCTAVES > (1 << OCT_W))) begin : g_octaves_check
        $error("tone_preset_gen: OCTAVES does not fit the octave field");
    end

    // Octave plus signed shift, clamped to the valid octave range.
    function automatic logic [OCT_W-1:0] sat_oct(input logic [OCT_W-1:0] o,
                                                 input logic signed [1:0] sh);
        logic signed [OCT_W+1:0] sum;
        sum = $signed({2'b00, o}) + $signed({{OCT_W{sh[1]}}, sh});
        if (sum[OCT_W+1]) return '0;
        if (sum > TOP_OCT_S) return TOP_OCT;
        return sum[OCT_W-1:0];
    endfunction

    // Top-octave period for each degree; degree 0 is a rest.
    function automatic logic [TO_W-1:0] base_period(input logic [2:0] d);
        case (d)
            3'd1:    return TO_W'(638);
            3'd2:    return TO_W'(568);
            3'd3:    return TO_W'(506);
            3'd4:    return TO_W'(478);
            3'd5:    return TO_W'(426);
            3'd6:    return TO_W'(380);
            3'd7:    return TO_W'(338);
            default: return '0;
        endcase
    endfunction

    // 2^TO_W - period, taken modulo 2^TO_W; period is never zero here.
    function automatic logic [TO_W-1:0] to_preset(input logic [TO_W-1:0] period);
        return TO_W'(0) - period;
    endfunction

    // ---------------- stage 0: source capture ----------------
    logic [NW-1:0] note_p0_q, note_p0_d;
    logic          vld_p0_q, vld_p0_d;
    logic          key_q, mode_q;
    logic          key_rise, key_fall;

    always_comb begin
        note_p0_d = note_p0_q;
        vld_p0_d  = 1'b0;
        key_rise  = bus.key_down_i & ~key_q;
        key_fall  = ~bus.key_down_i & key_q;
        if (bus.mode_i != mode_q) begin
            // A source switch starts from silence.
            note_p0_d = '0;
            vld_p0_d  = 1'b1;
        end else if (!bus.mode_i) begin
            if (bus.rom_stb_i) begin
                note_p0_d = bus.rom_note_i;
                vld_p0_d  = 1'b1;
            end
        end else if (key_rise) begin
            note_p0_d = bus.key_note_i;
            vld_p0_d  = 1'b1;
        end else if (key_fall) begin
            note_p0_d = '0;
            vld_p0_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            note_p0_q <= '0;
            vld_p0_q  <= 1'b0;
            key_q     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            note_p0_q <= note_p0_d;
            vld_p0_q  <= vld_p0_d;
            key_q     <= bus.key_down_i;
            mode_q    <= bus.mode_i;
        end
    end

    // ---------------- stage 1: decode ----------------
    logic [2:0]       deg_p1_q, deg_p1_d;
    logic [OCT_W-1:0] oct_p1_q, oct_p1_d;
    logic             rest_p1_q, rest_p1_d;
    logic             vld_p1_q;
    logic             bad_q, bad_d;
    logic [2:0]       deg_in;
    logic [OCT_W-1:0] oct_in;
    logic             bad_oct;

    always_comb begin
        deg_in    = note_p0_q[2:0];
        oct_in    = note_p0_q[NW-1:3];
        bad_oct   = {1'b0, oct_in} >= OCT_LIMIT;
        deg_p1_d  = deg_p1_q;
        oct_p1_d  = oct_p1_q;
        rest_p1_d = rest_p1_q;
        if (vld_p0_q) begin
            deg_p1_d  = deg_in;
            oct_p1_d  = sat_oct(oct_in, bus.oct_shift_i);
            rest_p1_d = (deg_in == 3'd0) | bad_oct;
        end
        // Only a newly captured note can raise the flag, so a held bad
        // note does not fight a later clear. Set beats clear.
        if (vld_p0_q && bad_oct)  bad_d = 1'b1;
        else if (bus.clr_bad_i)   bad_d = 1'b0;
        else                      bad_d = bad_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deg_p1_q  <= '0;
            oct_p1_q  <= '0;
            rest_p1_q <= 1'b1;
            vld_p1_q  <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            deg_p1_q  <= deg_p1_d;
            oct_p1_q  <= oct_p1_d;
            rest_p1_q <= rest_p1_d;
            vld_p1_q  <= vld_p0_q;
            bad_q     <= bad_d;
        end
    end

    // ---------------- stage 2: period ----------------
    logic [TO_W-1:0]  period_p2_q, period_p2_d;
    logic [2:0]       code_p2_q, code_p2_d;
    logic [OCT_W-1:0] oct_p2_q, oct_p2_d;
    logic             mute_p2_q, mute_p2_d;
    logic             vld_p2_q;

    always_comb begin
        period_p2_d = period_p2_q;
        code_p2_d   = code_p2_q;
        oct_p2_d    = oct_p2_q;
        mute_p2_d   = mute_p2_q;
        if (vld_p1_q) begin
            if (rest_p1_q) begin
                period_p2_d = '0;
                code_p2_d   = '0;
                oct_p2_d    = '0;
                mute_p2_d   = 1'b1;
            end else begin
                // Each octave below the top doubles the period.
                period_p2_d = base_period(deg_p1_q) << (TOP_OCT - oct_p1_q);
                code_p2_d   = deg_p1_q;
                oct_p2_d    = oct_p1_q;
                mute_p2_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_p2_q <= '0;
            code_p2_q   <= '0;
            oct_p2_q    <= '0;
            mute_p2_q   <= 1'b1;
            vld_p2_q    <= 1'b0;
        end else begin
            period_p2_q <= period_p2_d;
            code_p2_q   <= code_p2_d;
            oct_p2_q    <= oct_p2_d;
            mute_p2_q   <= mute_p2_d;
            vld_p2_q    <= vld_p1_q;
        end
    end

    // ---------------- output registers ----------------
    logic [TO_W-1:0] to_q, to_d;
    logic            to_load_q, to_load_d;
    logic [2:0]      code_q;
    logic [OCT_W-1:0] oct_q;
    logic            mute_q;

    always_comb begin
        to_d      = mute_p2_q ? '1 : to_preset(period_p2_q);
        // Re-issuing the same note leaves {TO, MUTE} unchanged: no pulse.
        to_load_d = vld_p2_q && ({to_d, mute_p2_q} != {to_q, mute_q});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_q      <= '1;
            code_q    <= '0;
            oct_q     <= '0;
            mute_q    <= 1'b1;
            to_load_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            code_q    <= code_p2_q;
            oct_q     <= oct_p2_q;
            mute_q    <= mute_p2_q;
            to_load_q <= to_load_d;
        end
    end

    assign bus.to_o       = to_q;
    assign bus.code_o     = code_q;
    assign bus.oct_o      = oct_q;
    assign bus.mute_o     = mute_q;
    assign bus.to_load_o  = to_load_q;
    assign bus.bad_note_o = bad_q;

endmodule
